// File: rtl/un_striper_pkg.sv
// Shared lane definitions for the striper / un_striper pair.
// Both sides agree on word width, lane count and which lane carries even words.
package un_striper_pkg;
  localparam int   DATA_W_DEF = 32;
  localparam int   LANES      = 2;
  localparam logic LANE0      = 1'b0;
  localparam logic LANE1      = 1'b1;
endpackage

// File: rtl/un_striper_lane_fifo.sv
// Small synchronous per-lane FIFO with a combinational head.
// A full FIFO that is popped on an edge still accepts a push on that edge.
module lane_fifo
  import un_striper_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/un_striper.sv
// Merges even (lane 0) and odd (lane 1) words back into one ordered stream.
// A select bit drains the lane FIFOs strictly alternately, stalling on an empty head.
module un_striper
  import un_striper_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] lane_0,
  input  logic              valid_0,
  input  logic [DATA_W-1:0] lane_1,
  input  logic              valid_1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              err_overflow
);
  logic [LANES-1:0]  push_v, pop_v, full_v, empty_v, drop_v;
  logic [DATA_W-1:0] din  [LANES];
  logic [DATA_W-1:0] head [LANES];

  logic              sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  assign din[LANE0]    = lane_0;
  assign din[LANE1]    = lane_1;
  assign push_v[LANE0] = valid_0;
  assign push_v[LANE1] = valid_1;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      // Only the selected lane may be popped; the other waits its turn.
      assign pop_v[gi]  = (int'(sel_q) == gi) && !empty_v[gi];
      assign drop_v[gi] = push_v[gi] && full_v[gi] && !pop_v[gi];

      lane_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk_2f (clk_2f),
        .reset  (reset),
        .push   (push_v[gi]),
        .pop    (pop_v[gi]),
        .din    (din[gi]),
        .dout   (head[gi]),
        .full   (full_v[gi]),
        .empty  (empty_v[gi])
      );
    end
  endgenerate

  always_comb begin
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = err_q | (|drop_v);
    if (!empty_v[sel_q]) begin
      data_d  = head[sel_q];
      valid_d = 1'b1;
      sel_d   = ~sel_q;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      sel_q   <= LANE0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data_out     = data_q;
  assign valid_out    = valid_q;
  assign err_overflow = err_q;
endmodule

// File: tb/tb_un_striper.sv
// Randomized and directed checks of un_striper against a queue-based model of
// the even/odd merge with per-lane capacity.
module tb_un_striper;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk_2f = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] lane_0, lane_1;
  logic              valid_0, valid_1;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              err_overflow;

  un_striper #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_2f       (clk_2f),
    .reset        (reset),
    .lane_0       (lane_0),
    .valid_0      (valid_0),
    .lane_1       (lane_1),
    .valid_1      (valid_1),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .err_overflow (err_overflow)
  );

  always #5 clk_2f = ~clk_2f;

  // Model: one queue per lane, a turn pointer and the expected outputs.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          m_sel;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_err;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v0, input logic [31:0] d0,
                      input logic v1, input logic [31:0] d1);
    reset = r; valid_0 = v0; lane_0 = d0; valid_1 = v1; lane_1 = d1;
    @(posedge clk_2f);
    if (r) begin
      q0.delete(); q1.delete();
      m_sel = 0; m_data = '0; m_valid = 1'b0; m_err = 1'b0;
    end else begin
      m_valid = 1'b0;
      // Words leave in strict even/odd turn; a pop frees space for a same-edge push.
      if (m_sel == 0 && q0.size() > 0) begin
        m_data = q0.pop_front(); m_valid = 1'b1; m_sel = 1;
      end else if (m_sel == 1 && q1.size() > 0) begin
        m_data = q1.pop_front(); m_valid = 1'b1; m_sel = 0;
      end
      if (v0) begin
        if (q0.size() < DEPTH) q0.push_back(d0); else m_err = 1'b1;
      end
      if (v1) begin
        if (q1.size() < DEPTH) q1.push_back(d1); else m_err = 1'b1;
      end
    end
    #1;
    check("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
    check("data_out", data_out, m_data);
    check("err_overflow", {31'b0, err_overflow}, {31'b0, m_err});
    if (valid_out) $display("out %h err=%0b", data_out, err_overflow);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    reset = 1'b1; valid_0 = 1'b0; valid_1 = 1'b0; lane_0 = '0; lane_1 = '0;
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, '0);

    // 1: first pair, one cycle of latency, even word first
    step(1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 32'hEEEEEEEE);
    idle();
    check("t1_first", data_out, 32'hFFFFFFFF);
    idle();
    check("t1_second", data_out, 32'hEEEEEEEE);
    check("t1_valid", {31'b0, valid_out}, 32'd1);

    // 2: pairs on alternate cycles stream out continuously
    step(1'b0, 1'b1, 32'hDDDDDDDD, 1'b1, 32'hCCCCCCCC);
    idle();
    step(1'b0, 1'b1, 32'hBBBBBBBB, 1'b1, 32'hAAAAAAAA);
    idle();
    idle();
    idle();
    check("t2_noerr", {31'b0, err_overflow}, 32'd0);

    // 3: odd word alone must wait for its even partner
    step(1'b0, 1'b0, '0, 1'b1, 32'h12345678);
    idle(); idle(); idle();
    step(1'b0, 1'b1, 32'h87654321, 1'b0, '0);
    idle(); idle(); idle();

    // 4: both lanes every cycle overfills the FIFOs
    for (int i = 0; i < 12; i++)
      step(1'b0, 1'b1, 32'h40000000 + 32'(2*i), 1'b1, 32'h40000000 + 32'(2*i+1));
    check("t4_err", {31'b0, err_overflow}, 32'd1);
    for (int i = 0; i < 10; i++) idle();

    // 5: reset with words buffered discards them
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h50, 1'b1, 32'h51);
    step(1'b0, 1'b1, 32'h52, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    check("t5_data", data_out, 32'h0);
    step(1'b0, 1'b1, 32'h0000000A, 1'b1, 32'h0000000B);
    idle(); idle(); idle();

    // 6: fill lane 0, then pop and push it on the same edge
    step(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h60 + 32'(i), 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b1, 32'h70);
    idle();
    step(1'b0, 1'b1, 32'h65, 1'b0, '0);
    check("t6_noerr", {31'b0, err_overflow}, 32'd0);
    for (int i = 1; i < 6; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 32'h70 + 32'(i));
      idle(); idle();
    end

    // Random traffic with varying density and occasional resets
    step(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 400; i++) begin
      int dens;
      dens = (i / 100) + 1;
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 4) < dens, $urandom,
           $urandom_range(0, 4) < dens, $urandom);
    end
    for (int i = 0; i < 12; i++) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
